// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with fill-level accounting, almost-full/empty thresholds and
// a choice of registered (1-cycle latency) or first-word-fall-through read port.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  W_INC,
  input  logic                  R_INC,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   FILL_LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_L    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_L    = AE_LEVEL[ADDR_WIDTH:0];

  if (ADDR_WIDTH < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH ||
      (FWFT != 0 && FWFT != 1)) begin : g_bad_params
    $fatal(1, "param_sync_fifo: illegal parameter set");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   fill_next;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance uses the registered flags as they stand before the edge.
  assign wr_ok = W_INC & ~FULL;
  assign rd_ok = R_INC & ~EMPTY;

  always_comb begin
    fill_next = FILL_LEVEL;
    case ({wr_ok, rd_ok})
      2'b10:   fill_next = FILL_LEVEL + 1'b1;
      2'b01:   fill_next = FILL_LEVEL - 1'b1;
      default: fill_next = FILL_LEVEL;
    endcase
  end

  // Flags are registered from the next fill level so they never glitch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      FILL_LEVEL   <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      FILL_LEVEL   <= fill_next;
      FULL         <= (fill_next == DEPTH_L);
      EMPTY        <= (fill_next == '0);
      ALMOST_FULL  <= (fill_next >= AF_L);
      ALMOST_EMPTY <= (fill_next <= AE_L);
      OVERFLOW     <= W_INC & FULL;
      UNDERFLOW    <= R_INC & EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok && !RST) mem[wr_ptr[ADDR_WIDTH-1:0]] <= WR_DATA;
  end

  if (FWFT == 0) begin : g_reg_read
    always_ff @(posedge CLK) begin
      if (RST) begin
        RD_DATA  <= '0;
        RD_VALID <= 1'b0;
      end else begin
        RD_VALID <= rd_ok;
        if (rd_ok) RD_DATA <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end else begin : g_fwft_read
    // Head word is visible whenever the FIFO holds data; zero while empty.
    assign RD_VALID = ~EMPTY;
    assign RD_DATA  = EMPTY ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

endmodule
